// File: rtl/icache_fetch_responder_if.sv
// Two-word refill read channel between the instruction cache (master) and its memory-side responder (slave).
interface icache_fetch_responder_if;
    logic [31:0] S_AXI_ARADDR1;
    logic [31:0] S_AXI_ARADDR2;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA1;
    logic [31:0] S_AXI_RDATA2;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        S_AXI_BREAK;

    modport master (
        output S_AXI_ARADDR1, S_AXI_ARADDR2, S_AXI_ARVALID, S_AXI_RREADY, S_AXI_BREAK,
        input  S_AXI_ARREADY, S_AXI_RDATA1, S_AXI_RDATA2, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARADDR1, S_AXI_ARADDR2, S_AXI_ARVALID, S_AXI_RREADY, S_AXI_BREAK,
        output S_AXI_ARREADY, S_AXI_RDATA1, S_AXI_RDATA2, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/icache_fetch_responder.sv
// Memory-side responder for the icache two-word refill: one request, one R beat after a down-counted latency.
// Define RANDOM_LATENCY_EN to add 0..7 LFSR-chosen cycles of latency per request.
//
// state  | meaning
// S_IDLE | ARREADY high, waiting for a request
// S_WAIT | request captured, latency counter running, BREAK cancels
// S_RESP | R beat presented and held until RREADY
module icache_fetch_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 3
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    icache_fetch_responder_if.slave  bus,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_addr,
    input  logic [31:0]              init_wdata
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_load;
    logic             arready, arready_nxt;
    logic             rvalid, rvalid_nxt;
    logic             capture;
    logic [31:0]      rdata1, rdata2;
    logic [1:0]       rresp;
    logic [33:0]      chk1, chk2;
    logic [31:0]      mem [DEPTH];

    always_ff @(posedge S_AXI_ACLK) begin
        if (init_we) mem[init_addr] <= init_wdata;
    end

    // Range test is done on the full 32-bit offset so wrapped addresses cannot alias into the array.
    function automatic logic [33:0] check_word(input logic [31:0] addr);
        logic [31:0]      off;
        logic [IDX_W-1:0] idx;
        off = addr - BASE_ADDR;
        idx = IDX_W'(off >> 2);
        if (addr < BASE_ADDR || (off >> 2) >= 32'(DEPTH)) return {2'b11, 32'h0};
        if (addr[1:0] != 2'b00) return {2'b10, 32'h0};
        return {2'b00, mem[idx]};
    endfunction

    assign chk1 = check_word(bus.S_AXI_ARADDR1);
    assign chk2 = check_word(bus.S_AXI_ARADDR2);

`ifdef RANDOM_LATENCY_EN
    logic [7:0] lfsr;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) lfsr <= 8'hA5;
        else                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign cnt_load = LAT_LOAD + CNT_W'(lfsr[2:0]);
`else
    assign cnt_load = LAT_LOAD;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        arready_nxt = arready;
        rvalid_nxt  = rvalid;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                arready_nxt = 1'b1;
                if (bus.S_AXI_ARVALID && arready) begin
                    capture     = 1'b1;
                    arready_nxt = 1'b0;
                    cnt_nxt     = cnt_load;
                    state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.S_AXI_BREAK) begin
                    arready_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (cnt == '0) begin
                    rvalid_nxt = 1'b1;
                    state_nxt  = S_RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.S_AXI_RREADY) begin
                    rvalid_nxt  = 1'b0;
                    arready_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state   <= S_IDLE;
            cnt     <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata1  <= '0;
            rdata2  <= '0;
            rresp   <= 2'b00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            arready <= arready_nxt;
            rvalid  <= rvalid_nxt;
            if (capture) begin
                rdata1 <= chk1[31:0];
                rdata2 <= chk2[31:0];
                rresp  <= (chk1[33:32] > chk2[33:32]) ? chk1[33:32] : chk2[33:32];
            end
        end
    end

    assign bus.S_AXI_ARREADY = arready;
    assign bus.S_AXI_RVALID  = rvalid;
    assign bus.S_AXI_RDATA1  = rdata1;
    assign bus.S_AXI_RDATA2  = rdata2;
    assign bus.S_AXI_RRESP   = rresp;
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scenario bench for icache_fetch_responder: expected R beats are queued at the AR handshake and checked on RVALID.
module tb_icache_fetch_responder;
    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we = 1'b0;
    logic [9:0]  init_addr = '0;
    logic [31:0] init_wdata = '0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] tb_mem [1024];
    exp_t        sb [$];

    always #5 clk = ~clk;

    icache_fetch_responder_if bus ();

    icache_fetch_responder #(
        .BASE_ADDR(32'h4000_0000),
        .DEPTH    (1024),
        .LATENCY  (3)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .bus          (bus),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_wdata   (init_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference address decode, written from the address rules rather than from the RTL.
    task automatic model_word(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] idx;
        d = 32'h0;
        r = 2'b00;
        if (addr < 32'h4000_0000) begin
            r = 2'b11;
        end else begin
            idx = (addr - 32'h4000_0000) / 4;
            if (idx >= 1024) r = 2'b11;
            else if (addr % 4 != 0) r = 2'b10;
            else d = tb_mem[idx[9:0]];
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        init_we    = 1'b1;
        init_addr  = idx[9:0];
        init_wdata = data;
        tb_mem[idx] = data;
        tick();
        init_we = 1'b0;
    endtask

    task automatic send_req(input logic [31:0] a1, input logic [31:0] a2);
        exp_t        e;
        logic [1:0]  r1, r2;
        int          n;
        bus.S_AXI_ARADDR1 = a1;
        bus.S_AXI_ARADDR2 = a2;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL arready_timeout: arready=%b required=1 within 20 cycles", bus.S_AXI_ARREADY);
        end else begin
            model_word(a1, e.d1, r1);
            model_word(a2, e.d2, r2);
            e.resp = (r1 > r2) ? r1 : r2;
            sb.push_back(e);
            tick();
        end
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_rvalid(output int cyc);
        cyc = 0;
        while (bus.S_AXI_RVALID !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        if (bus.S_AXI_RVALID !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.S_AXI_ARADDR1 = '0;
        bus.S_AXI_ARADDR2 = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        bus.S_AXI_BREAK   = 1'b0;
        #3;
        checks++;
        if ({bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RRESP} !== 4'b0000 ||
            bus.S_AXI_RDATA1 !== 32'h0 || bus.S_AXI_RDATA2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: arready=%b rvalid=%b rresp=%b rdata1=%h rdata2=%h required all 0",
                     bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA1, bus.S_AXI_RDATA2);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL arready_before_edge: arready=%b required=0", bus.S_AXI_ARREADY);
        end
        tick();
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL arready_after_release: arready=%b required=1", bus.S_AXI_ARREADY);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   cyc;
        preload(0, 32'h0000_0013);
        preload(1, 32'h0010_0093);
        preload(5, 32'h1111_1111);
        preload(1023, 32'hDEAD_BEEF);
        bus.S_AXI_RREADY = 1'b1;
        send_req(32'h4000_0000, 32'h4000_0004);
        wait_rvalid(cyc);
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL basic_latency: cycles=%0d required=3", cyc);
        end
        checks++;
        if (cyc > 0 && (bus.S_AXI_RDATA1 !== 32'h0000_0013 || bus.S_AXI_RDATA2 !== 32'h0010_0093 || bus.S_AXI_RRESP !== 2'b00)) begin
            failures++;
            $display("FAIL basic_data: rdata1=%h rdata2=%h rresp=%b required 00000013 00100093 00",
                     bus.S_AXI_RDATA1, bus.S_AXI_RDATA2, bus.S_AXI_RRESP);
        end
        e = sb.pop_front();
        tick();
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b0) begin
            failures++;
            $display("FAIL basic_rearm: arready=%b rvalid=%b required 1 0", bus.S_AXI_ARREADY, bus.S_AXI_RVALID);
        end
    endtask

    task automatic test_address_checks();
        logic [31:0] tbl_a1 [8];
        logic [31:0] tbl_a2 [8];
        exp_t        e;
        int          cyc;
        tbl_a1 = '{32'h4000_1000, 32'h4000_0002, 32'h3FFF_FFFC, 32'h4000_0FFC,
                   32'h4000_0004, 32'hFFFF_FFFC, 32'h4000_0014, 32'h4000_0003};
        tbl_a2 = '{32'h4000_0000, 32'h4000_0006, 32'h4000_0FFC, 32'h4000_0003,
                   32'h4000_0000, 32'h4000_0014, 32'h4000_1004, 32'h4000_0004};
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_req(tbl_a1[i], tbl_a2[i]);
            wait_rvalid(cyc);
            checks++;
            if (cyc != 3) begin
                failures++;
                $display("FAIL addr_latency[%0d]: cycles=%0d required=3", i, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.S_AXI_RDATA1 !== e.d1 || bus.S_AXI_RDATA2 !== e.d2 || bus.S_AXI_RRESP !== e.resp) begin
                    failures++;
                    $display("FAIL addr_beat[%0d]: rdata1=%h rdata2=%h rresp=%b required %h %h %b",
                             i, bus.S_AXI_RDATA1, bus.S_AXI_RDATA2, bus.S_AXI_RRESP, e.d1, e.d2, e.resp);
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL addr_sb_drain: left=%0d required=0", sb.size());
        end
    endtask

    task automatic test_break();
        exp_t e;
        int   cyc;
        bit   seen;
        bus.S_AXI_RREADY = 1'b1;
        send_req(32'h4000_0000, 32'h4000_0004);
        if (sb.size() != 0) e = sb.pop_back();
        bus.S_AXI_BREAK = 1'b1;
        tick();
        bus.S_AXI_BREAK = 1'b0;
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b0) begin
            failures++;
            $display("FAIL break_rearm: arready=%b rvalid=%b required 1 0", bus.S_AXI_ARREADY, bus.S_AXI_RVALID);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.S_AXI_RVALID !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL break_no_beat: rvalid seen=1 required=0");
        end
        // BREAK arriving on the expiry cycle still wins
        send_req(32'h4000_0000, 32'h4000_0004);
        if (sb.size() != 0) e = sb.pop_back();
        tick();
        tick();
        bus.S_AXI_BREAK = 1'b1;
        tick();
        bus.S_AXI_BREAK = 1'b0;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL break_priority: rvalid=%b arready=%b required 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        send_req(32'h4000_0004, 32'h4000_0000);
        wait_rvalid(cyc);
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL break_after_latency: cycles=%0d required=3", cyc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.S_AXI_RDATA1 !== e.d1 || bus.S_AXI_RDATA2 !== e.d2 || bus.S_AXI_RRESP !== e.resp) begin
                failures++;
                $display("FAIL break_after_beat: rdata1=%h rdata2=%h rresp=%b required %h %h %b",
                         bus.S_AXI_RDATA1, bus.S_AXI_RDATA2, bus.S_AXI_RRESP, e.d1, e.d2, e.resp);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        bit   bad;
        bus.S_AXI_RREADY = 1'b0;
        send_req(32'h4000_0014, 32'h4000_0000);
        wait_rvalid(cyc);
        checks++;
        if (cyc != 3) begin
            failures++;
            $display("FAIL bp_latency: cycles=%0d required=3", cyc);
        end
        e.d1 = 32'h0;
        e.d2 = 32'h0;
        e.resp = 2'b00;
        if (sb.size() != 0) e = sb.pop_front();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.S_AXI_BREAK = (i == 2);
            preload(5, 32'h2222_0000 + i);
            bus.S_AXI_BREAK = 1'b0;
            if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA1 !== e.d1 ||
                bus.S_AXI_RDATA2 !== e.d2 || bus.S_AXI_RRESP !== e.resp) bad = 1'b1;
        end
        checks++;
        if (bad || e.d1 !== 32'h1111_1111) begin
            failures++;
            $display("FAIL bp_hold: rvalid=%b rdata1=%h rdata2=%h rresp=%b required 1 11111111 %h %b",
                     bus.S_AXI_RVALID, bus.S_AXI_RDATA1, bus.S_AXI_RDATA2, bus.S_AXI_RRESP, e.d2, e.resp);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: rvalid=%b arready=%b required 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        send_req(32'h4000_0014, 32'h4000_0014);
        wait_rvalid(cyc);
        checks++;
        if (cyc <= 0 || bus.S_AXI_RDATA1 !== 32'h2222_0004 || bus.S_AXI_RDATA2 !== 32'h2222_0004) begin
            failures++;
            $display("FAIL bp_new_data: cycles=%0d rdata1=%h rdata2=%h required 22220004", cyc, bus.S_AXI_RDATA1, bus.S_AXI_RDATA2);
        end
        if (sb.size() != 0) e = sb.pop_front();
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        bus.S_AXI_RREADY = 1'b1;
        send_req(32'h4000_0000, 32'h4000_0004);
        if (sb.size() != 0) e = sb.pop_back();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait: rvalid=%b arready=%b required 0 0", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_rearm: arready=%b required=1", bus.S_AXI_ARREADY);
        end
        bus.S_AXI_RREADY = 1'b0;
        send_req(32'h4000_0004, 32'h4000_0000);
        if (sb.size() != 0) e = sb.pop_back();
        wait_rvalid(cyc);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cyc <= 0 || bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL rst_resp: cycles=%0d rvalid=%b arready=%b required rvalid 0 arready 0", cyc, bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
        tick();
        rst_n = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        tick();
        checks++;
        if (bus.S_AXI_ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL rst_resp_rearm: arready=%b required=1", bus.S_AXI_ARREADY);
        end
        send_req(32'h4000_0000, 32'h4000_0FFC);
        wait_rvalid(cyc);
        checks++;
        if (cyc != 3 || bus.S_AXI_RDATA1 !== 32'h0000_0013 || bus.S_AXI_RDATA2 !== 32'hDEAD_BEEF || bus.S_AXI_RRESP !== 2'b00) begin
            failures++;
            $display("FAIL rst_mem_intact: cycles=%0d rdata1=%h rdata2=%h rresp=%b required 3 00000013 deadbeef 00",
                     cyc, bus.S_AXI_RDATA1, bus.S_AXI_RDATA2, bus.S_AXI_RRESP);
        end
        if (sb.size() != 0) e = sb.pop_front();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_address_checks();
        test_break();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- AXI-style read responder (memory side) for the instruction cache's two-word refill interface.
- Accepts one request carrying two word addresses (ARADDR1/ARADDR2).
- Returns both words in a single R beat after a configurable latency, with range and alignment checking.
- Honours the cache's cancel (break) signal, so a cancelled miss produces no R beat.
- Backed by an internal word array that is preloaded through a side write port; used as simulation memory and as the fetch-path BRAM wrapper.

Parameters:
- BASE_ADDR, 32'h40000000: byte address of word 0.
- DEPTH, 1024: number of 32-bit words in the array; power of 2.
- LATENCY, 3: cycles from AR handshake to first RVALID; legal 1..15.

Ports:
- S_AXI_ACLK  in  1  clock, rising edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_ARADDR1  in  32  first word byte address.
- S_AXI_ARADDR2  in  32  second word byte address.
- S_AXI_ARVALID  in  1  request valid.
- S_AXI_ARREADY  out  1  request accepted when high with ARVALID.
- S_AXI_RDATA1  out  32  word at ARADDR1.
- S_AXI_RDATA2  out  32  word at ARADDR2.
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- S_AXI_RVALID  out  1  response valid.
- S_AXI_RREADY  in  1  response consumed when high with RVALID.
- S_AXI_BREAK  in  1  cancel the outstanding request (cache hit).
- init_we  in  1  preload write enable.
- init_addr  in  $clog2(DEPTH)  preload word index.
- init_wdata  in  32  preload data.

Behaviour:
- Reset (async assert, sync release):
  - ARREADY=0, RVALID=0, RDATA1/RDATA2=0, RRESP=00, state=IDLE, latency counter=0.
  - Array contents are not reset.
  - ARREADY rises on the first clock edge after release.
- States:
  - IDLE: ARREADY=1. On ARVALID&&ARREADY, capture addresses, decode, array data and RRESP; clear ARREADY; load counter=LATENCY-1; go to WAIT.
  - WAIT: if BREAK=1, go to IDLE next edge with ARREADY=1 and no R beat. Else if counter==0, go to RESP and set RVALID=1. Else decrement the counter. BREAK has priority over expiry.
  - RESP: RVALID, RDATA1, RDATA2 and RRESP are held stable until RREADY. On RVALID&&RREADY: RVALID=0, ARREADY=1, go to IDLE. BREAK is ignored in RESP and IDLE.
- Timing:
  - Handshake on edge N puts RVALID high after edge N+LATENCY.
  - The earliest next handshake is the edge after the R handshake.
  - Only one request is outstanding.
- Address check, per address, at capture:
  - idx = (addr - BASE_ADDR) >> 2.
  - DECERR if addr < BASE_ADDR or idx >= DEPTH.
  - Otherwise SLVERR if addr[1:0] != 0.
  - A failing word returns data 0.
  - RRESP is the worse of the two results; DECERR beats SLVERR beats OKAY.
  - Subtraction is 32-bit unsigned; the comparison is done before truncation to the index width.
- Data capture:
  - Array data is read at the handshake edge.
  - An init write to the same index in the same cycle returns the old data.
  - init writes are accepted in any state, including reset-released IDLE.
- Reset asserted mid-WAIT or mid-RESP drops the request; RVALID falls immediately (asynchronously).

Optional Feature:
- RANDOM_LATENCY_EN defined:
  - An 8-bit Fibonacci LFSR (seed 8'hA5 on reset, taps 8,6,5,4) advances every cycle.
  - At each handshake, LFSR[2:0] is added to the counter load, giving total latency LATENCY..LATENCY+7.
  - This stresses the cache's wait logic.
- Not defined: latency is exactly LATENCY; no LFSR logic is present.

Test Plan:
- Reset release, then preload idx0=32'h00000013 and idx1=32'h00100093; request ARADDR1=40000000, ARADDR2=40000004 with RREADY=1 → RVALID exactly 3 cycles after handshake, RDATA1=00000013, RDATA2=00100093, RRESP=00, ARREADY high the following cycle.
- ARADDR1=40001000 (idx 1024), ARADDR2=40000000 → RRESP=11, RDATA1=0, RDATA2=word0.
- ARADDR1=40000002, ARADDR2=40000006 → RRESP=10, both data 0.
- Handshake, then BREAK=1 one cycle later → no RVALID ever; ARREADY=1 on the next edge; a new request then completes normally.
- Hold RREADY=0 for 5 cycles after RVALID while changing the preload of the same index → RVALID, RDATA and RRESP stable and carrying the old value; completes on the RREADY edge.
- ARESETN low during WAIT → RVALID=0 and ARREADY=0 immediately; after release, ARREADY=1 within 1 cycle and the preloaded data is intact.
